module_keypad_scanner: RTL and testbench
========================================

MODULE_KEYPAD_SCANNER -- requirements
Module: module_keypad_scanner

Interface
REQ-001 Parameter N_ROWS, default 4, number of keypad rows sensed (2..8).
REQ-002 Parameter N_COLS, default 4, number of keypad columns driven (2..8).
REQ-003 Parameter SCAN_DIV, default 1000, clock cycles each column is driven while scanning (>=4).
REQ-004 Parameter DEBOUNCE_CYC, default 50000, consecutive stable cycles required for press and for release (>=2).
REQ-005 Port clk_i  input  1  single system clock; all state updates on rising edge.
REQ-006 Port rst_n_i  input  1  asynchronous, active-low reset.
REQ-007 Port fila_i  input  N_ROWS  raw row lines, active-low, asynchronous to clk_i.
REQ-008 Port column_o  output  N_COLS  column drive, active-low one-cold.
REQ-009 Port key_code_o  output  CW=$clog2(N_ROWS*N_COLS)  code of the reported key.
REQ-010 Port key_valid_o  output  1  key_code_o holds a new key.
REQ-011 Port key_ready_i  input  1  consumer accepts key_code_o.

Function
REQ-012 fila_i SHALL pass through a 2-flop synchroniser; all logic uses the synchronised value rs.
REQ-013 A row pattern is valid when exactly one bit of rs is 0; row_idx is that bit's index. All-ones is idle. Any other pattern is invalid and treated as idle.
REQ-014 column_o SHALL drive exactly one 0, at bit col_idx; col_idx in 0..N_COLS-1.
REQ-015 FSM states: SCAN, DEBOUNCE, REPORT, RELEASE.
REQ-016 SCAN: a divider counts 0..SCAN_DIV-1. On terminal count col_idx advances, wrapping N_COLS-1 -> 0, and the divider restarts.
REQ-017 SCAN: a valid row pattern seen in the 3rd or later cycle of a column dwell (settling) SHALL capture rs into ref_pat and row_idx. The FSM then enters DEBOUNCE, col_idx frozen, debounce counter = 1.
REQ-018 DEBOUNCE: each cycle with rs == ref_pat increments the counter. Any mismatch returns to SCAN with the divider cleared and col_idx advanced.
REQ-019 DEBOUNCE: when the counter reaches DEBOUNCE_CYC, the FSM enters REPORT.
REQ-020 REPORT: key_code_o = row_idx*N_COLS + col_idx, registered. key_valid_o = 1.
REQ-021 key_valid_o and key_code_o SHALL stay stable until a cycle with key_valid_o && key_ready_i. That cycle is the transfer. Next cycle key_valid_o = 0 and the FSM is in RELEASE.
REQ-022 A held key SHALL produce exactly one transfer. No auto-repeat.
REQ-023 RELEASE: col_idx stays frozen. The counter counts consecutive idle cycles of rs and clears on any non-idle cycle.
REQ-024 RELEASE: at DEBOUNCE_CYC idle cycles, the FSM enters SCAN with col_idx advanced and the divider cleared.
REQ-025 key_code_o SHALL retain the last reported code when key_valid_o = 0.
REQ-026 Key-to-valid latency from a clean fila_i edge SHALL equal 2 (sync) + settle + DEBOUNCE_CYC + 1 cycles.
REQ-027 key_ready_i is ignored outside REPORT.

Reset
REQ-028 While rst_n_i = 0, the block SHALL be: state SCAN, col_idx 0, column_o = {N_COLS-1{1}},0, key_valid_o 0, key_code_o 0, all counters and synchroniser flops cleared (sync flops to all-ones).
REQ-029 Reset asserted mid-DEBOUNCE, REPORT or RELEASE SHALL abort the operation immediately, with no transfer. After deassertion, scanning restarts from column 0.
REQ-030 The first scan column change after reset SHALL occur SCAN_DIV cycles after rst_n_i deasserts.

Verification (N_ROWS=4, N_COLS=4, SCAN_DIV=8, DEBOUNCE_CYC=6)
REQ-031 Bench: no key pressed -> column_o cycles 1110, 1101, 1011, 0111, 1110, each held 8 cycles; key_valid_o never asserts.
REQ-032 Bench: key row 2 / col 1 held (fila_i = 1011 while column_o = 1101), key_ready_i = 1 -> exactly one key_valid_o pulse with key_code_o = 9; no second pulse until release plus 6 idle cycles.
REQ-033 Bench: key row 3 / col 3, key_ready_i = 0 for 20 cycles then 1 -> key_valid_o high and key_code_o = 15 stable throughout; valid drops the cycle after ready.
REQ-034 Bench: bounce (row 0 pulses low 3 cycles, high 1 cycle, repeated) -> no report, scan continues. A following stable press of 10 cycles -> report code = col_idx.
REQ-035 Bench: two rows low simultaneously (fila_i = 1001) -> ignored, no report, scan keeps advancing.
REQ-036 Bench: rst_n_i pulsed low while key_valid_o = 1 -> key_valid_o = 0 and column_o = 1110 asynchronously; no transfer counted.

Source files
------------

// File: rtl/module_keypad_scanner.sv
// Matrix keypad scanner: walks a one-cold column drive, debounces the row response
// and hands each debounced key press to a valid/ready consumer exactly once.
module module_keypad_scanner #(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 50000,
  localparam int CW          = $clog2(N_ROWS*N_COLS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [N_ROWS-1:0] fila_i,
  output logic [N_COLS-1:0] column_o,
  output logic [CW-1:0]     key_code_o,
  output logic              key_valid_o,
  input  logic              key_ready_i
);

  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CIW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int NW  = $clog2(DEBOUNCE_CYC + 1);
  localparam int ZW  = $clog2(N_ROWS + 1);
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [NW-1:0]  DEB_LAST = NW'(DEBOUNCE_CYC - 1);
  localparam logic [CIW-1:0] COL_LAST = CIW'(N_COLS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, REPORT, RELEASE} state_t;

  state_t            state, state_n;
  logic [N_ROWS-1:0] sync1, rs;
  logic [N_ROWS-1:0] ref_pat, ref_pat_n;
  logic [RW-1:0]     row_idx, row_idx_n;
  logic [CIW-1:0]    col_idx, col_idx_n, col_adv;
  logic [DW-1:0]     div, div_n;
  logic [NW-1:0]     cnt, cnt_n;
  logic [CW-1:0]     key_code, key_code_n;

  // Row decode: exactly one low line is a key; anything else counts as idle.
  logic [ZW-1:0] n_low;
  logic [RW-1:0] low_idx;
  logic          row_ok;

  always_comb begin
    n_low   = '0;
    low_idx = '0;
    for (int i = 0; i < N_ROWS; i++) begin
      if (!rs[i]) begin
        n_low   = n_low + 1'b1;
        low_idx = RW'(i);
      end
    end
    row_ok = (n_low == ZW'(1));
  end

  assign col_adv = (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;

  always_comb begin
    for (int i = 0; i < N_COLS; i++) column_o[i] = (col_idx != CIW'(i));
  end

  always_comb begin
    state_n    = state;
    ref_pat_n  = ref_pat;
    row_idx_n  = row_idx;
    col_idx_n  = col_idx;
    div_n      = div;
    cnt_n      = cnt;
    key_code_n = key_code;
    case (state)
      SCAN: begin
        if (div == DIV_LAST) begin
          div_n     = '0;
          col_idx_n = col_adv;
        end else begin
          div_n = div + 1'b1;
        end
        // The first two cycles of a dwell still show the previous column through the synchroniser.
        if (row_ok && div >= DW'(2)) begin
          state_n   = DEBOUNCE;
          ref_pat_n = rs;
          row_idx_n = low_idx;
          col_idx_n = col_idx;
          div_n     = '0;
          cnt_n     = NW'(1);
        end
      end
      DEBOUNCE: begin
        if (rs == ref_pat) begin
          if (cnt == DEB_LAST) begin
            state_n    = REPORT;
            key_code_n = CW'(row_idx) * CW'(N_COLS) + CW'(col_idx);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end else begin
          state_n   = SCAN;
          div_n     = '0;
          col_idx_n = col_adv;
          cnt_n     = '0;
        end
      end
      REPORT: begin
        if (key_ready_i) begin
          state_n = RELEASE;
          cnt_n   = '0;
        end
      end
      RELEASE: begin
        if (row_ok) begin
          cnt_n = '0;
        end else if (cnt == DEB_LAST) begin
          state_n   = SCAN;
          div_n     = '0;
          col_idx_n = col_adv;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = SCAN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= SCAN;
      sync1    <= '1;
      rs       <= '1;
      ref_pat  <= '1;
      row_idx  <= '0;
      col_idx  <= '0;
      div      <= '0;
      cnt      <= '0;
      key_code <= '0;
    end else begin
      state    <= state_n;
      sync1    <= fila_i;
      rs       <= sync1;
      ref_pat  <= ref_pat_n;
      row_idx  <= row_idx_n;
      col_idx  <= col_idx_n;
      div      <= div_n;
      cnt      <= cnt_n;
      key_code <= key_code_n;
    end
  end

  assign key_valid_o = (state == REPORT);
  assign key_code_o  = key_code;

endmodule

// File: tb/tb_module_keypad_scanner.sv
// Scenario bench for the keypad scanner: a keypad model closes the row/column loop,
// expected key codes are queued at press time and matched at each transfer.
module tb_module_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] fila;
  logic [3:0] column;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  logic       key_on, raw_mode;
  logic [1:0] key_row, key_col;
  logic [3:0] raw_pat;

  int total = 0, bad = 0, transfers = 0, col_changes = 0, valid_hi = 0;
  logic [3:0] prev_col = 4'b1110;
  logic [3:0] exp_t;
  logic [3:0] exp_q[$];
  logic [3:0] exp_col[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  module_keypad_scanner #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(8), .DEBOUNCE_CYC(6)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .fila_i(fila), .column_o(column),
    .key_code_o(key_code), .key_valid_o(key_valid), .key_ready_i(key_ready)
  );

  always #5 clk = ~clk;

  // Keypad model: a closed switch pulls its row low only while its column is driven.
  always_comb begin
    fila = 4'hF;
    if (raw_mode) fila = raw_pat;
    else if (key_on && column[key_col] == 1'b0) fila = ~(4'b0001 << key_row);
  end

  // Transfer monitor, sampled 1 time unit before each rising edge.
  always begin
    @(negedge clk); #4;
    if (rst_n) begin
      if (key_valid) valid_hi++;
      if (column != prev_col) col_changes++;
      prev_col = column;
      if (key_valid && key_ready) begin
        transfers++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_transfer code=%0d expected none", key_code);
        end else begin
          exp_t = exp_q.pop_front();
          if (key_code !== exp_t) begin
            bad++;
            $display("FAIL transfer_code got=%0d exp=%0d", key_code, exp_t);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 200 && !key_valid; i++) tick(1);
    total++;
    if (key_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout valid=%b exp=1", name, key_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_ready = 1'b0; key_on = 1'b0; raw_mode = 1'b0;
    raw_pat = 4'hF; key_row = '0; key_col = '0;
    tick(3);
    total += 3;
    if (column !== 4'b1110) begin bad++; $display("FAIL reset_column got=%b exp=1110", column); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
    if (key_code !== 4'd0) begin bad++; $display("FAIL reset_code got=%0d exp=0", key_code); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      total++;
      if (column !== exp_col[(c / 8) % 4]) begin
        bad++;
        $display("FAIL idle_scan c=%0d got=%b exp=%b", c, column, exp_col[(c / 8) % 4]);
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (valid_hi != 0) begin bad++; $display("FAIL idle_no_valid got=%0d exp=0", valid_hi); end
  endtask

  task automatic test_single_key();
    int t0;
    t0 = transfers;
    key_ready = 1'b1; key_row = 2'd2; key_col = 2'd1; key_on = 1'b1;
    exp_q.push_back(4'd9);
    for (int i = 0; i < 200 && transfers == t0; i++) tick(1);
    total += 2;
    if (transfers != t0 + 1) begin bad++; $display("FAIL single_timeout got=%0d exp=%0d", transfers, t0 + 1); end
    if (key_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_width valid=%b exp=0", key_valid); end
    tick(40);
    total++;
    if (transfers != t0 + 1) begin bad++; $display("FAIL single_no_repeat got=%0d exp=%0d", transfers, t0 + 1); end
    key_on = 1'b0;
    tick(20);
    total++;
    if (transfers != t0 + 1) begin bad++; $display("FAIL single_after_release got=%0d exp=%0d", transfers, t0 + 1); end
  endtask

  task automatic test_hold_ready();
    int t0;
    t0 = transfers;
    key_ready = 1'b0; key_row = 2'd3; key_col = 2'd3; key_on = 1'b1;
    exp_q.push_back(4'd15);
    wait_valid("hold");
    for (int i = 0; i < 20; i++) begin
      total += 2;
      if (key_valid !== 1'b1) begin bad++; $display("FAIL hold_valid i=%0d got=%b exp=1", i, key_valid); end
      if (key_code !== 4'd15) begin bad++; $display("FAIL hold_code i=%0d got=%0d exp=15", i, key_code); end
      tick(1);
    end
    key_ready = 1'b1;
    tick(1);
    total += 2;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL hold_drop got=%b exp=0", key_valid); end
    if (transfers != t0 + 1) begin bad++; $display("FAIL hold_count got=%0d exp=%0d", transfers, t0 + 1); end
    key_on = 1'b0;
    tick(20);
  endtask

  task automatic test_bounce();
    int t0, c0;
    t0 = transfers; c0 = col_changes;
    key_ready = 1'b1; raw_mode = 1'b1;
    for (int r = 0; r < 20; r++) begin
      raw_pat = 4'b1110; tick(3);
      raw_pat = 4'b1111; tick(1);
    end
    total += 2;
    if (transfers != t0) begin bad++; $display("FAIL bounce_no_report got=%0d exp=%0d", transfers, t0); end
    if (col_changes - c0 < 2) begin bad++; $display("FAIL bounce_scan got=%0d exp>=2", col_changes - c0); end
    for (int i = 0; i < 100 && column != 4'b1011; i++) tick(1);
    total++;
    if (column !== 4'b1011) begin bad++; $display("FAIL bounce_col_wait got=%b exp=1011", column); end
    exp_q.push_back(4'd2);
    raw_pat = 4'b1110; tick(10);
    raw_pat = 4'b1111; tick(20);
    total++;
    if (transfers != t0 + 1) begin bad++; $display("FAIL stable_report got=%0d exp=%0d", transfers, t0 + 1); end
  endtask

  task automatic test_two_rows();
    int t0, c0;
    t0 = transfers; c0 = col_changes;
    key_ready = 1'b1; raw_mode = 1'b1; raw_pat = 4'b1001;
    tick(60);
    total += 2;
    if (transfers != t0) begin bad++; $display("FAIL two_rows_no_report got=%0d exp=%0d", transfers, t0); end
    if (col_changes - c0 < 5) begin bad++; $display("FAIL two_rows_scan got=%0d exp>=5", col_changes - c0); end
    raw_pat = 4'hF; raw_mode = 1'b0;
    tick(5);
  endtask

  task automatic test_reset_mid();
    int t0;
    t0 = transfers;
    key_ready = 1'b0; key_row = 2'd1; key_col = 2'd0; key_on = 1'b1;
    wait_valid("mid");
    total++;
    if (key_code !== 4'd4) begin bad++; $display("FAIL mid_code got=%0d exp=4", key_code); end
    rst_n = 1'b0;
    #1;
    total += 2;
    if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", key_valid); end
    if (column !== 4'b1110) begin bad++; $display("FAIL mid_async_column got=%b exp=1110", column); end
    key_ready = 1'b1; key_on = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    total++;
    if (transfers != t0) begin bad++; $display("FAIL mid_no_transfer got=%0d exp=%0d", transfers, t0); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_hold_ready();
    test_bounce();
    test_two_rows();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL pending_expected got=%0d exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
